// File: rtl/mem_access.sv
// Load/store stage of the RV32I core: one single-beat AXI4 read or write per
// memory instruction, load alignment/extension, and the registered M_* outputs.
module mem_access #(
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_M_AXI_ADDR_WIDTH      = 32,
   parameter int C_M_AXI_DATA_WIDTH      = 32,
   parameter int C_M_AXI_AWUSER_WIDTH    = 1,
   parameter int C_M_AXI_ARUSER_WIDTH    = 1,
   parameter int C_M_AXI_WUSER_WIDTH     = 4,
   parameter int C_M_AXI_BUSER_WIDTH     = 1,
   parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                STALL,
   output logic                                MEM_WAIT,
   input  logic                                E_VALID,
   input  logic [31:0]                         E_PC,
   input  logic                                E_MEM_RD,
   input  logic                                E_MEM_WR,
   input  logic [2:0]                          E_FUNCT3,
   input  logic [31:0]                         E_ADDR,
   input  logic [31:0]                         E_WDATA,
   input  logic [4:0]                          E_REG_D,
   input  logic [31:0]                         E_RESULT,
   output logic                                M_VALID,
   output logic [31:0]                         M_PC,
   output logic [4:0]                          M_REG_D,
   output logic [31:0]                         M_REG_D_V,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_DATA_AXI_AWID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_DATA_AXI_AWADDR,
   output logic [7:0]                          M_DATA_AXI_AWLEN,
   output logic [2:0]                          M_DATA_AXI_AWSIZE,
   output logic [1:0]                          M_DATA_AXI_AWBURST,
   output logic                                M_DATA_AXI_AWLOCK,
   output logic [3:0]                          M_DATA_AXI_AWCACHE,
   output logic [2:0]                          M_DATA_AXI_AWPROT,
   output logic [3:0]                          M_DATA_AXI_AWQOS,
   output logic [C_M_AXI_AWUSER_WIDTH-1:0]     M_DATA_AXI_AWUSER,
   output logic                                M_DATA_AXI_AWVALID,
   input  logic                                M_DATA_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]       M_DATA_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_DATA_AXI_WSTRB,
   output logic                                M_DATA_AXI_WLAST,
   output logic [C_M_AXI_WUSER_WIDTH-1:0]      M_DATA_AXI_WUSER,
   output logic                                M_DATA_AXI_WVALID,
   input  logic                                M_DATA_AXI_WREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_DATA_AXI_BID,
   input  logic [1:0]                          M_DATA_AXI_BRESP,
   input  logic [C_M_AXI_BUSER_WIDTH-1:0]      M_DATA_AXI_BUSER,
   input  logic                                M_DATA_AXI_BVALID,
   output logic                                M_DATA_AXI_BREADY,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_DATA_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_DATA_AXI_ARADDR,
   output logic [7:0]                          M_DATA_AXI_ARLEN,
   output logic [2:0]                          M_DATA_AXI_ARSIZE,
   output logic [1:0]                          M_DATA_AXI_ARBURST,
   output logic                                M_DATA_AXI_ARLOCK,
   output logic [3:0]                          M_DATA_AXI_ARCACHE,
   output logic [2:0]                          M_DATA_AXI_ARPROT,
   output logic [3:0]                          M_DATA_AXI_ARQOS,
   output logic [C_M_AXI_ARUSER_WIDTH-1:0]     M_DATA_AXI_ARUSER,
   output logic                                M_DATA_AXI_ARVALID,
   input  logic                                M_DATA_AXI_ARREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]  M_DATA_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]       M_DATA_AXI_RDATA,
   input  logic [1:0]                          M_DATA_AXI_RRESP,
   input  logic                                M_DATA_AXI_RLAST,
   input  logic [C_M_AXI_RUSER_WIDTH-1:0]      M_DATA_AXI_RUSER,
   input  logic                                M_DATA_AXI_RVALID,
   output logic                                M_DATA_AXI_RREADY
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

   state_t      state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        m_valid_q;
   logic [31:0] m_pc_q;
   logic [4:0]  m_reg_d_q;
   logic [31:0] m_reg_d_v_q;
   logic [1:0]  lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] st_data;
   logic [3:0]  st_strb;
   logic        aw_ok, w_ok;
   logic        unused_inputs;

   assign lane = E_ADDR[1:0];

   // Transfer sequencing: next state, per-channel handshake tracking, read capture.
   always_comb begin
      state_d   = state_q;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      rbuf_d    = rbuf_q;
      aw_ok     = aw_done_q | M_DATA_AXI_AWREADY;
      w_ok      = w_done_q | M_DATA_AXI_WREADY;
      case (state_q)
         IDLE: begin
            if (E_VALID && E_MEM_RD)      state_d = RD_ADDR;
            else if (E_VALID && E_MEM_WR) state_d = WR_REQ;
         end
         RD_ADDR: if (M_DATA_AXI_ARREADY) state_d = RD_DATA;
         RD_DATA: begin
            if (M_DATA_AXI_RVALID) begin
               rbuf_d  = M_DATA_AXI_RDATA[31:0];
               state_d = DONE;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; leave only once both have.
            if (aw_ok && w_ok) begin
               state_d = WR_RESP;
            end else begin
               aw_done_d = aw_ok;
               w_done_d  = w_ok;
            end
         end
         WR_RESP: if (M_DATA_AXI_BVALID) state_d = DONE;
         DONE:    if (!STALL) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state and write-handshake flags.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Read data buffer, consumed while the FSM sits in DONE.
   always_ff @(posedge CLK) begin
      rbuf_q <= rbuf_d;
   end

   // Load alignment and sign/zero extension.
   always_comb begin
      ld_byte = rbuf_q[8*lane +: 8];
      ld_half = lane[1] ? rbuf_q[31:16] : rbuf_q[15:0];
      case (E_FUNCT3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h000000, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0000, ld_half};
         default: ld_data = rbuf_q;
      endcase
   end

   // Store lane replication and byte strobes.
   always_comb begin
      case (E_FUNCT3[1:0])
         2'b00: begin
            st_data = {4{E_WDATA[7:0]}};
            st_strb = 4'b0001 << lane;
         end
         2'b01: begin
            st_data = {2{E_WDATA[15:0]}};
            st_strb = 4'b0011 << {lane[1], 1'b0};
         end
         default: begin
            st_data = E_WDATA;
            st_strb = 4'b1111;
         end
      endcase
   end

   assign MEM_WAIT = E_VALID & (E_MEM_RD | E_MEM_WR) & (state_q != DONE);

   // Stage output register; advances only when nothing stalls the pipe.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         m_valid_q   <= 1'b0;
         m_pc_q      <= '0;
         m_reg_d_q   <= '0;
         m_reg_d_v_q <= '0;
      end else if (!STALL && !MEM_WAIT) begin
         m_valid_q   <= E_VALID;
         m_pc_q      <= E_PC;
         m_reg_d_q   <= E_REG_D;
         m_reg_d_v_q <= E_MEM_RD ? ld_data : E_RESULT;
      end
   end

   assign M_VALID   = m_valid_q;
   assign M_PC      = m_pc_q;
   assign M_REG_D   = m_reg_d_q;
   assign M_REG_D_V = m_reg_d_v_q;

   assign M_DATA_AXI_AWID    = '0;
   assign M_DATA_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({E_ADDR[31:2], 2'b00});
   assign M_DATA_AXI_AWLEN   = 8'd0;
   assign M_DATA_AXI_AWSIZE  = 3'b010;
   assign M_DATA_AXI_AWBURST = 2'b01;
   assign M_DATA_AXI_AWLOCK  = 1'b0;
   assign M_DATA_AXI_AWCACHE = 4'b0011;
   assign M_DATA_AXI_AWPROT  = 3'b000;
   assign M_DATA_AXI_AWQOS   = 4'b0000;
   assign M_DATA_AXI_AWUSER  = '0;
   assign M_DATA_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
   assign M_DATA_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(st_data);
   assign M_DATA_AXI_WSTRB   = (C_M_AXI_DATA_WIDTH/8)'(st_strb);
   assign M_DATA_AXI_WLAST   = 1'b1;
   assign M_DATA_AXI_WUSER   = '0;
   assign M_DATA_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
   assign M_DATA_AXI_BREADY  = (state_q == WR_RESP);
   assign M_DATA_AXI_ARID    = '0;
   assign M_DATA_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({E_ADDR[31:2], 2'b00});
   assign M_DATA_AXI_ARLEN   = 8'd0;
   assign M_DATA_AXI_ARSIZE  = 3'b010;
   assign M_DATA_AXI_ARBURST = 2'b01;
   assign M_DATA_AXI_ARLOCK  = 1'b0;
   assign M_DATA_AXI_ARCACHE = 4'b0011;
   assign M_DATA_AXI_ARPROT  = 3'b000;
   assign M_DATA_AXI_ARQOS   = 4'b0000;
   assign M_DATA_AXI_ARUSER  = '0;
   assign M_DATA_AXI_ARVALID = (state_q == RD_ADDR);
   assign M_DATA_AXI_RREADY  = (state_q == RD_DATA);

   assign unused_inputs = ^{M_DATA_AXI_BID, M_DATA_AXI_BRESP, M_DATA_AXI_BUSER,
                            M_DATA_AXI_RID, M_DATA_AXI_RRESP, M_DATA_AXI_RLAST,
                            M_DATA_AXI_RUSER, M_DATA_AXI_RDATA};

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: AXI slave with programmable ready/response delays,
// handshake monitor, and a scoreboard of expected stage outputs.
module tb_mem_access;

   logic        CLK, RST, STALL, MEM_WAIT;
   logic        E_VALID, E_MEM_RD, E_MEM_WR;
   logic [31:0] E_PC, E_ADDR, E_WDATA, E_RESULT;
   logic [2:0]  E_FUNCT3;
   logic [4:0]  E_REG_D;
   logic        M_VALID;
   logic [31:0] M_PC, M_REG_D_V;
   logic [4:0]  M_REG_D;

   logic [0:0]  AWID, ARID, BID, RID;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWLOCK, ARLOCK;
   logic [3:0]  AWCACHE, ARCACHE, AWQOS, ARQOS, WSTRB, WUSER, RUSER;
   logic [0:0]  AWUSER, ARUSER, BUSER;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ar_log[$];
   logic [31:0] aw_log[$];
   logic [35:0] w_log[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned axi_act = 0;
   logic        bready_bad = 1'b0;
   logic        stall_extra = 1'b0;
   int unsigned ar_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
   logic [31:0] rd_word = '0;
   logic [31:0] pc_ctr = 32'h100;
   logic [4:0]  reg_ctr = 5'd1;

   assign STALL = MEM_WAIT | stall_extra;

   mem_access dut (
      .CLK(CLK), .RST(RST), .STALL(STALL), .MEM_WAIT(MEM_WAIT),
      .E_VALID(E_VALID), .E_PC(E_PC), .E_MEM_RD(E_MEM_RD), .E_MEM_WR(E_MEM_WR),
      .E_FUNCT3(E_FUNCT3), .E_ADDR(E_ADDR), .E_WDATA(E_WDATA), .E_REG_D(E_REG_D),
      .E_RESULT(E_RESULT), .M_VALID(M_VALID), .M_PC(M_PC), .M_REG_D(M_REG_D),
      .M_REG_D_V(M_REG_D_V),
      .M_DATA_AXI_AWID(AWID), .M_DATA_AXI_AWADDR(AWADDR), .M_DATA_AXI_AWLEN(AWLEN),
      .M_DATA_AXI_AWSIZE(AWSIZE), .M_DATA_AXI_AWBURST(AWBURST), .M_DATA_AXI_AWLOCK(AWLOCK),
      .M_DATA_AXI_AWCACHE(AWCACHE), .M_DATA_AXI_AWPROT(AWPROT), .M_DATA_AXI_AWQOS(AWQOS),
      .M_DATA_AXI_AWUSER(AWUSER), .M_DATA_AXI_AWVALID(AWVALID), .M_DATA_AXI_AWREADY(AWREADY),
      .M_DATA_AXI_WDATA(WDATA), .M_DATA_AXI_WSTRB(WSTRB), .M_DATA_AXI_WLAST(WLAST),
      .M_DATA_AXI_WUSER(WUSER), .M_DATA_AXI_WVALID(WVALID), .M_DATA_AXI_WREADY(WREADY),
      .M_DATA_AXI_BID(BID), .M_DATA_AXI_BRESP(BRESP), .M_DATA_AXI_BUSER(BUSER),
      .M_DATA_AXI_BVALID(BVALID), .M_DATA_AXI_BREADY(BREADY),
      .M_DATA_AXI_ARID(ARID), .M_DATA_AXI_ARADDR(ARADDR), .M_DATA_AXI_ARLEN(ARLEN),
      .M_DATA_AXI_ARSIZE(ARSIZE), .M_DATA_AXI_ARBURST(ARBURST), .M_DATA_AXI_ARLOCK(ARLOCK),
      .M_DATA_AXI_ARCACHE(ARCACHE), .M_DATA_AXI_ARPROT(ARPROT), .M_DATA_AXI_ARQOS(ARQOS),
      .M_DATA_AXI_ARUSER(ARUSER), .M_DATA_AXI_ARVALID(ARVALID), .M_DATA_AXI_ARREADY(ARREADY),
      .M_DATA_AXI_RID(RID), .M_DATA_AXI_RDATA(RDATA), .M_DATA_AXI_RRESP(RRESP),
      .M_DATA_AXI_RLAST(RLAST), .M_DATA_AXI_RUSER(RUSER), .M_DATA_AXI_RVALID(RVALID),
      .M_DATA_AXI_RREADY(RREADY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Slave: each channel raises its ready/valid after a programmable number of cycles.
   initial begin
      int unsigned ac, wc, awc, bc, rc;
      ac = 0; wc = 0; awc = 0; bc = 0; rc = 0;
      ARREADY = 0; AWREADY = 0; WREADY = 0; BVALID = 0; RVALID = 0;
      RDATA = '0; RID = '0; BID = '0; RRESP = '0; BRESP = '0; RLAST = 1'b1;
      RUSER = '0; BUSER = '0;
      forever begin
         @(negedge CLK);
         if (ARVALID) begin
            if (ac >= ar_delay) ARREADY = 1; else begin ARREADY = 0; ac++; end
         end else begin ARREADY = 0; ac = 0; end
         if (AWVALID) begin
            if (awc >= aw_delay) AWREADY = 1; else begin AWREADY = 0; awc++; end
         end else begin AWREADY = 0; awc = 0; end
         if (WVALID) begin
            if (wc >= w_delay) WREADY = 1; else begin WREADY = 0; wc++; end
         end else begin WREADY = 0; wc = 0; end
         if (BREADY) begin
            if (bc >= b_delay) BVALID = 1; else begin BVALID = 0; bc++; end
         end else begin BVALID = 0; bc = 0; end
         if (RREADY) begin
            if (rc >= r_delay) begin RVALID = 1; RDATA = rd_word; end
            else begin RVALID = 0; rc++; end
         end else begin RVALID = 0; rc = 0; end
      end
   end

   // Handshake monitor: logs completed address/data beats.
   always @(posedge CLK) begin
      if (RST) begin
         if (BREADY && (aw_log.size() != w_log.size())) bready_bad = 1'b1;
         if (ARVALID || AWVALID || WVALID) axi_act++;
         if (ARVALID && ARREADY) ar_log.push_back(ARADDR);
         if (AWVALID && AWREADY) aw_log.push_back(AWADDR);
         if (WVALID && WREADY) w_log.push_back({WSTRB, WDATA});
      end
   end

   task automatic idle();
      E_VALID = 0; E_MEM_RD = 0; E_MEM_WR = 0;
      @(posedge CLK); #1;
   endtask

   // Drives one instruction, waits for it, and scores the loaded stage output.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] result, input logic [31:0] rword,
                         input logic [31:0] expv, input int unsigned stall_done,
                         output int unsigned wait_cycles);
      exp_t e, got;
      pc_ctr  = pc_ctr + 32'd4;
      reg_ctr = reg_ctr + 5'd1;
      rd_word = rword;
      stall_extra = (stall_done != 0);
      E_VALID = 1; E_MEM_RD = rd; E_MEM_WR = wr; E_FUNCT3 = f3; E_ADDR = addr;
      E_WDATA = wdata; E_RESULT = result; E_PC = pc_ctr; E_REG_D = reg_ctr;
      e.pc = pc_ctr; e.rd = reg_ctr; e.val = expv;
      exp_q.push_back(e);
      #1;
      wait_cycles = 0;
      while (MEM_WAIT === 1'b1 && wait_cycles < 200) begin
         @(posedge CLK); #1;
         wait_cycles++;
      end
      checks++;
      if (MEM_WAIT !== 1'b0) begin
         errors++;
         $display("FAIL mem_wait_timeout: MEM_WAIT=%b after %0d cycles, want 0", MEM_WAIT, wait_cycles);
      end
      for (int unsigned i = 0; i < stall_done; i++) begin
         @(posedge CLK); #1;
         checks++;
         if (M_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: M_VALID=%b during stall cycle %0d, want 0", M_VALID, i);
         end
      end
      stall_extra = 0;
      @(posedge CLK); #1;
      got = exp_q.pop_front();
      checks++;
      if ({M_VALID, M_PC, M_REG_D} !== {1'b1, got.pc, got.rd}) begin
         errors++;
         $display("FAIL out_ctl: valid=%b pc=%h rd=%0d, want 1 pc=%h rd=%0d",
                  M_VALID, M_PC, M_REG_D, got.pc, got.rd);
      end
      checks++;
      if (M_REG_D_V !== got.val) begin
         errors++;
         $display("FAIL out_data: M_REG_D_V=%h, want %h", M_REG_D_V, got.val);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({M_VALID, AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl: valids=%b, want 000000",
                  {M_VALID, AWVALID, WVALID, ARVALID, BREADY, RREADY});
      end
      checks++;
      if ({M_PC, M_REG_D, M_REG_D_V} !== 69'b0) begin
         errors++;
         $display("FAIL reset_out: pc=%h rd=%0d v=%h, want 0", M_PC, M_REG_D, M_REG_D_V);
      end
   endtask

   task automatic test_loads();
      int unsigned w;
      int unsigned n0;
      n0 = ar_log.size();
      ar_delay = 3; r_delay = 0;
      run_op(1, 0, 3'b000, 32'h1003, '0, '0, 32'h80FF1234, 32'hFFFFFF80, 0, w);
      idle();
      checks++;
      if (w != 6) begin
         errors++;
         $display("FAIL lb_wait: MEM_WAIT cycles=%0d, want 6", w);
      end
      checks++;
      if (ar_log.size() != n0 + 1 || ar_log[n0] !== 32'h1000) begin
         errors++;
         $display("FAIL lb_araddr: count=%0d addr=%h, want 1 addr 00001000",
                  ar_log.size() - n0, ar_log[ar_log.size()-1]);
      end
      run_op(1, 0, 3'b100, 32'h1003, '0, '0, 32'h80FF1234, 32'h00000080, 0, w);
      idle();
      run_op(1, 0, 3'b001, 32'h1002, '0, '0, 32'h80FF1234, 32'hFFFF80FF, 0, w);
      idle();
      run_op(1, 0, 3'b101, 32'h1003, '0, '0, 32'h80FF1234, 32'h000080FF, 0, w);
      idle();
      ar_delay = 0;
   endtask

   task automatic test_store_half();
      int unsigned w;
      int unsigned a0, w0;
      a0 = aw_log.size(); w0 = w_log.size();
      aw_delay = 2; w_delay = 0; b_delay = 0;
      run_op(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h00000011, '0, 32'h00000011, 0, w);
      idle();
      checks++;
      if (aw_log.size() != a0 + 1 || aw_log[a0] !== 32'h2000) begin
         errors++;
         $display("FAIL sh_aw: count=%0d addr=%h, want 1 addr 00002000",
                  aw_log.size() - a0, aw_log[aw_log.size()-1]);
      end
      checks++;
      if (w_log.size() != w0 + 1 || w_log[w0] !== {4'b1100, 32'hBEEFBEEF}) begin
         errors++;
         $display("FAIL sh_w: count=%0d beat=%h, want 1 beat c_beefbeef",
                  w_log.size() - w0, w_log[w_log.size()-1]);
      end
      checks++;
      if (bready_bad !== 1'b0) begin
         errors++;
         $display("FAIL sh_bready: BREADY seen before both handshakes (flag=%b), want 0", bready_bad);
      end
      aw_delay = 0;
      run_op(0, 1, 3'b000, 32'h2001, 32'h000000A5, 32'h00000022, '0, 32'h00000022, 0, w);
      idle();
      checks++;
      if (w_log[w_log.size()-1] !== {4'b0010, 32'hA5A5A5A5}) begin
         errors++;
         $display("FAIL sb_w: beat=%h, want 2_a5a5a5a5", w_log[w_log.size()-1]);
      end
   endtask

   task automatic test_store_word_stall();
      int unsigned w;
      int unsigned a0, w0;
      a0 = aw_log.size(); w0 = w_log.size();
      aw_delay = 0; w_delay = 0; b_delay = 5;
      run_op(0, 1, 3'b010, 32'h2010, 32'h13579BDF, 32'hDEAD0001, '0, 32'hDEAD0001, 2, w);
      idle();
      checks++;
      if (aw_log.size() != a0 + 1 || w_log.size() != w0 + 1) begin
         errors++;
         $display("FAIL sw_single: aw=%0d w=%0d, want 1 and 1", aw_log.size() - a0, w_log.size() - w0);
      end
      checks++;
      if (w_log[w_log.size()-1] !== {4'b1111, 32'h13579BDF} || aw_log[aw_log.size()-1] !== 32'h2010) begin
         errors++;
         $display("FAIL sw_beat: beat=%h addr=%h, want f_13579bdf addr 00002010",
                  w_log[w_log.size()-1], aw_log[aw_log.size()-1]);
      end
      b_delay = 0;
   endtask

   task automatic test_non_mem();
      int unsigned w;
      int unsigned act0;
      act0 = axi_act;
      run_op(0, 0, 3'b000, 32'h4000, '0, 32'h12345678, '0, 32'h12345678, 0, w);
      checks++;
      if (w != 0 || axi_act != act0) begin
         errors++;
         $display("FAIL nonmem_quiet: wait=%0d axi_cycles=%0d, want 0 and 0", w, axi_act - act0);
      end
   endtask

   // Leaves the previous non-memory result in M_* and aborts a read mid-flight.
   task automatic test_reset_mid_read();
      int unsigned n;
      r_delay = 1000;
      E_VALID = 1; E_MEM_RD = 1; E_MEM_WR = 0; E_FUNCT3 = 3'b010; E_ADDR = 32'h5000;
      n = 0;
      while (RREADY !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
      checks++;
      if (RREADY !== 1'b1 || M_VALID !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: RREADY=%b M_VALID=%b, want 1 1", RREADY, M_VALID);
      end
      RST = 0;
      @(posedge CLK); #1;
      checks++;
      if ({ARVALID, RREADY, M_VALID} !== 3'b000 || M_PC !== '0 || M_REG_D_V !== '0) begin
         errors++;
         $display("FAIL mid_reset: ar=%b rr=%b mv=%b pc=%h v=%h, want 0 0 0 0 0",
                  ARVALID, RREADY, M_VALID, M_PC, M_REG_D_V);
      end
      checks++;
      if (MEM_WAIT !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_wait_load: MEM_WAIT=%b, want 1", MEM_WAIT);
      end
      RST = 1; E_VALID = 0; E_MEM_RD = 0;
      #1;
      checks++;
      if (MEM_WAIT !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_wait_idle: MEM_WAIT=%b, want 0", MEM_WAIT);
      end
      r_delay = 0;
      @(posedge CLK); #1;
      checks++;
      if ({ARVALID, RREADY, AWVALID, WVALID} !== 4'b0) begin
         errors++;
         $display("FAIL post_reset_idle: ar=%b rr=%b aw=%b w=%b, want 0", ARVALID, RREADY, AWVALID, WVALID);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned w;
      int unsigned n0;
      n0 = ar_log.size();
      ar_delay = 0; r_delay = 0;
      run_op(1, 0, 3'b010, 32'h3000, '0, '0, 32'hAAAA5555, 32'hAAAA5555, 0, w);
      run_op(1, 0, 3'b010, 32'h3004, '0, '0, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, w);
      idle();
      checks++;
      if (ar_log.size() != n0 + 2 || ar_log[n0] !== 32'h3000 || ar_log[n0+1] !== 32'h3004) begin
         errors++;
         $display("FAIL b2b_ar: count=%0d last=%h, want 2 ordered 00003000,00003004",
                  ar_log.size() - n0, ar_log[ar_log.size()-1]);
      end
   endtask

   initial begin
      RST = 0; E_VALID = 0; E_MEM_RD = 0; E_MEM_WR = 0; E_FUNCT3 = '0;
      E_PC = '0; E_ADDR = '0; E_WDATA = '0; E_REG_D = '0; E_RESULT = '0;
      repeat (3) @(posedge CLK);
      #1;
      test_reset();
      RST = 1;
      idle();
      test_loads();
      test_store_half();
      test_store_word_stall();
      test_non_mem();
      test_reset_mid_read();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access (load/store) pipeline stage of the RV32I core. Sits directly downstream of the execute stage and upstream of write-back.
- Performs single-beat AXI4 reads/writes on the data master port (M_DATA_AXI_*).
- Aligns/extends load data and forwards the destination register and its value.
- Asserts MEM_WAIT while a transfer is outstanding; the core ORs it into the global stall.

Parameters:
C_M_AXI_THREAD_ID_WIDTH, 1, AXI ID width
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_M_AXI_AWUSER_WIDTH / ARUSER / WUSER / BUSER / RUSER, 1/1/4/1/4, user widths (driven 0 / ignored)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-low reset
STALL  in  1  global stall (includes MEM_WAIT)
MEM_WAIT  out  1  memory op at input not yet complete
E_VALID  in  1  execute-stage output valid
E_PC  in  32  instruction PC
E_MEM_RD / E_MEM_WR  in  1 / 1  load / store (mutually exclusive)
E_FUNCT3  in  3  access size/sign
E_ADDR  in  32  effective address
E_WDATA  in  32  store data (rs2)
E_REG_D  in  5  destination register
E_RESULT  in  32  ALU result (non-memory ops)
M_VALID, M_PC, M_REG_D, M_REG_D_V  out  1,32,5,32  registered stage outputs
M_AXI_AW* / AR*  out  per AXI4  address channels (constants: LEN=0, SIZE=010, BURST=01, LOCK=0, CACHE=0011, PROT=0, QOS=0, ID/USER=0)
M_AXI_AWREADY, ARREADY, WREADY, BVALID, RVALID, RDATA, RRESP, BRESP, RID, BID, RLAST, RUSER, BUSER  in
M_AXI_WDATA, WSTRB, WLAST(=1), WUSER(=0), WVALID, BREADY, RREADY  out

Behaviour:
- Reset (RST=0 at edge): state=IDLE. M_VALID, AWVALID, WVALID, ARVALID, BREADY, RREADY = 0. M_PC, M_REG_D, M_REG_D_V = 0. Applies mid-transfer; the interconnect is reset together with the core.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, E_VALID & E_MEM_RD:
  - Next state RD_ADDR, ARVALID=1, ARADDR={E_ADDR[31:2],2'b00}.
  - ARVALID & ARREADY -> RD_DATA, RREADY=1.
  - RVALID -> capture RDATA into rbuf, go to DONE.
- IDLE, E_VALID & E_MEM_WR:
  - Next state WR_REQ, AWVALID=WVALID=1, AWADDR word-aligned.
  - Each valid drops independently after its own handshake.
  - Both handshakes done (either order, or same cycle) -> WR_RESP, BREADY=1.
  - BVALID -> DONE.
- DONE: STALL=0 -> IDLE and output register loads. STALL=1 -> hold DONE; never re-issue.
- MEM_WAIT = E_VALID & (E_MEM_RD|E_MEM_WR) & (state != DONE). Combinational from state and E_* only; no path from STALL.
- Output register:
  - Loads when STALL=0 and MEM_WAIT=0; otherwise holds all M_* values.
  - On load: M_VALID=E_VALID, M_PC=E_PC, M_REG_D=E_REG_D.
  - M_REG_D_V = aligned load data for loads, E_RESULT otherwise (stores: E_RESULT, write-back ignores).
- Load extraction: lane=E_ADDR[1:0].
  - funct3 000 LB: sign-extend byte[lane].
  - 100 LBU: zero-extend byte[lane].
  - 001 LH: sign-extend half[lane[1]]; 101 LHU: zero-extend half[lane[1]].
  - 010 LW: full word.
  - Misaligned: LH/LHU ignore addr[0]; LW ignores addr[1:0].
- Store lanes:
  - SB: WDATA={4{byte}}, WSTRB=0001<<lane.
  - SH: WDATA={2{half}}, WSTRB=0011<<{lane[1],0}.
  - SW: WDATA=E_WDATA, WSTRB=1111.
- AXI address/data held stable while the corresponding VALID is high. RRESP/BRESP ignored.
- E_* inputs held stable by upstream while MEM_WAIT=1.
- RVALID or BVALID outside the expected state is ignored.

Test Plan:
- Reset mid RD_DATA (RST=0 one cycle) -> next cycle ARVALID=RREADY=M_VALID=0, state IDLE, MEM_WAIT follows E_* only.
- LB, E_ADDR=0x1003, RDATA=0x80FF1234, ARREADY delayed 3 cycles -> ARADDR=0x1000, MEM_WAIT high until DONE, M_REG_D_V=0xFFFFFF80; LBU same -> 0x00000080.
- SH, E_ADDR=0x2002, E_WDATA=0x0000BEEF, WREADY 2 cycles before AWREADY -> WDATA=0xBEEFBEEF, WSTRB=1100, AWADDR=0x2000, BREADY after both handshakes, single write.
- SW with AWREADY/WREADY same cycle, BVALID after 5 cycles, STALL held 2 extra cycles in DONE -> no second AW/W; M_VALID=1 only after STALL drops.
- Non-memory op E_RESULT=0x12345678, STALL=0 -> MEM_WAIT=0, no AXI activity, M_REG_D_V=0x12345678 next cycle.
- Back-to-back LW 0x3000 then LW 0x3004 (RDATA 0xAAAA5555, 0x0F0F0F0F) -> two ARs in order, outputs 0xAAAA5555 then 0x0F0F0F0F.
